queue_obj: RTL and testbench

Parameterised circular FIFO with a show-ahead head and a `halt` (empty) flag. It is used as the rename-stage free list of physical registers. Freed registers from the retirement RAT are enqueued, and the renamer dequeues one register per writing instruction. Optionally, reset preloads the queue with physical registers LENGTH..2·LENGTH−1.

---
 rtl/queue_obj_pkg.sv | 16 +
 rtl/queue_obj.sv | 71 +++++++
 tb/tb_queue_obj.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/queue_obj_pkg.sv
// Shared rename-stage constants: physical register tag width
// and the pointer-width helper used by the free list and the RATs.
package queue_obj_pkg;

    localparam int PREG_TAG_W = 6;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/queue_obj.sv
// Circular show-ahead FIFO, used as the rename free list of
// physical registers; reset can preload tags LENGTH..2*LENGTH-1.
module queue_obj
    import queue_obj_pkg::*;
#(
    parameter int LENGTH        = 32,
    parameter int WIDTH         = PREG_TAG_W,
    parameter bit FILL_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             enque,
    input  logic [WIDTH-1:0] enque_data,
    input  logic             deque,
    output logic [WIDTH-1:0] deque_data,
    output logic             halt
);

    localparam int PW = clog2(LENGTH);
    localparam logic [PW:0] FULL = (PW+1)'(LENGTH);

    logic [WIDTH-1:0] mem [LENGTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    logic empty;
    logic pop;
    logic push;

    assign empty = (count == '0);
    assign pop   = deque && !stall && !flush && !empty;
    // a full queue still takes a push when a pop frees a slot
    assign push  = enque && ((count != FULL) || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                mem[i] <= FILL_ON_RESET ? WIDTH'(LENGTH + i) : '0;
            end
        end else if (push) begin
            mem[tail] <= enque_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= FILL_ON_RESET ? FULL : '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign deque_data = empty ? '0 : mem[head];
    assign halt       = empty;

endmodule

// File: tb/tb_queue_obj.sv
// Bench for the free-list FIFO: queue-based reference model,
// per-cycle output compare, directed scenarios and random traffic.
module tb_queue_obj;

    localparam int LENGTH = 32;
    localparam int WIDTH  = 6;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             enque = 1'b0;
    logic [WIDTH-1:0] enque_data = '0;
    logic             deque = 1'b0;
    logic [WIDTH-1:0] deque_data;
    logic             halt;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int model_q [$];
    int popped  [$];

    queue_obj #(
        .LENGTH(LENGTH),
        .WIDTH(WIDTH),
        .FILL_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .enque(enque),
        .enque_data(enque_data),
        .deque(deque),
        .deque_data(deque_data),
        .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: reset refills the list with LENGTH..2*LENGTH-1
    always @(negedge reset) begin
        model_q.delete();
        for (int i = 0; i < LENGTH; i++) model_q.push_back(LENGTH + i);
    end

    always @(posedge clk) begin
        if (reset) begin
            if (deque && !stall && !flush && model_q.size() != 0) begin
                popped.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (enque && model_q.size() < LENGTH) begin
                model_q.push_back(int'(enque_data));
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && reset) begin
            chk("model_data", int'(deque_data),
                model_q.size() != 0 ? model_q[0] : 0);
            chk("model_halt", int'(halt), model_q.size() == 0 ? 1 : 0);
        end
    end

    task automatic drive(input bit e, input int ed, input bit d,
                         input bit s, input bit f);
        @(negedge clk);
        enque      = e;
        enque_data = WIDTH'(ed);
        deque      = d;
        stall      = s;
        flush      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulsed between edges; outputs must restore before any edge
    task automatic pulse_reset();
        @(negedge clk);
        enque = 1'b0;
        deque = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("async_rst_data", int'(deque_data), 32);
        chk("async_rst_halt", int'(halt), 0);
        #1 reset = 1'b1;
        popped.delete();
    endtask

    initial begin
        bit saw9;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_data", int'(deque_data), 32);
        chk("rst_halt", int'(halt), 0);
        check_en = 1'b1;

        popped.delete();
        repeat (32) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) chk("drain_order", popped[i], 32 + i);
        chk("drain_halt", int'(halt), 1);
        chk("drain_data", int'(deque_data), 0);

        repeat (3) begin
            drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
            chk("empty_pop_halt", int'(halt), 1);
        end

        drive(1'b1, 5, 1'b1, 1'b0, 1'b0);
        chk("push_empty_data", int'(deque_data), 5);
        chk("push_empty_halt", int'(halt), 0);

        pulse_reset();
        drive(1'b1, 7, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_head", int'(deque_data), 33);
        repeat (31) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_tail", int'(deque_data), 7);

        pulse_reset();
        drive(1'b1, 9, 1'b0, 1'b0, 1'b0);
        repeat (32) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        saw9 = 1'b0;
        foreach (popped[i]) if (popped[i] == 9) saw9 = 1'b1;
        chk("overflow_dropped", int'(saw9), 0);
        chk("overflow_halt", int'(halt), 1);

        pulse_reset();
        repeat (4) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 40, 1'b1, 1'b1, 1'b0);
        chk("stall_head", int'(deque_data), 36);
        drive(1'b1, 41, 1'b1, 1'b0, 1'b1);
        chk("flush_head", int'(deque_data), 36);
        repeat (28) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("stall_push_kept", int'(deque_data), 40);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("flush_push_kept", int'(deque_data), 41);

        for (int seg = 0; seg < 8; seg++) begin
            int pe;
            int pd;
            pe = (seg % 2 == 0) ? 30 : 75;
            pd = (seg % 2 == 0) ? 75 : 30;
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 299) == 0) begin
                    pulse_reset();
                end else begin
                    drive($urandom_range(0, 99) < pe,
                          int'($urandom_range(0, 63)),
                          $urandom_range(0, 99) < pd,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0);
                end
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
